// File: rtl/mode_seq_pkg.sv
// Shared types for the mode sequencer: FSM states, mode width and the mode-advance helper.
package mode_seq_pkg;

  localparam int NUM_MODES = 4;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_SWITCH = 2'd2,
    S_START  = 2'd3
  } state_e;

  // NUM_MODES is a power of two, so the natural 2-bit wrap is the modulo.
  function automatic mode_t next_mode(input mode_t m);
    return m + mode_t'(1);
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Button/datapath handshake bundle between the sequencer and its surroundings.
interface mode_sequencer_if;
  import mode_seq_pkg::*;

  logic  select_btn;
  logic  dp_idle;
  mode_t mode;
  logic  dp_stop;
  logic  dp_start;
  logic  busy;
  logic  timeout_flag;
  logic  btn_level;

  modport slave (
    input  select_btn, dp_idle,
    output mode, dp_stop, dp_start, busy, timeout_flag, btn_level
  );

  modport master (
    output select_btn, dp_idle,
    input  mode, dp_stop, dp_start, busy, timeout_flag, btn_level
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-edge pulse for a raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples disagreeing with the accepted level; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/mode_sequencer.sv
// Advances the datapath mode on each debounced button press: drain, switch, start strobe.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACK_TIMEOUT     = 255
) (
  input logic             clk,
  input logic             reset,
  mode_sequencer_if.slave bus
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);

  logic          sel_pulse;
  logic          btn_level;
  state_e        state_q;
  mode_t         mode_q;
  logic          dp_stop_q, dp_start_q, busy_q, tflag_q;
  logic [CW-1:0] drain_cnt_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.select_btn),
    .level_o (btn_level),
    .pulse_o (sel_pulse)
  );

  // Outputs are registered alongside the state they belong to; presses outside RUN are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      mode_q      <= '0;
      dp_stop_q   <= 1'b0;
      dp_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      tflag_q     <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      dp_start_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (sel_pulse) begin
            state_q     <= S_DRAIN;
            dp_stop_q   <= 1'b1;
            busy_q      <= 1'b1;
            drain_cnt_q <= '0;
          end
        end
        S_DRAIN: begin
          // An ack in the final cycle wins over the timeout.
          if (bus.dp_idle) begin
            state_q <= S_SWITCH;
          end else if (drain_cnt_q == TO_LAST) begin
            state_q <= S_SWITCH;
            tflag_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CW'(1);
          end
        end
        S_SWITCH: begin
          mode_q     <= next_mode(mode_q);
          dp_stop_q  <= 1'b0;
          dp_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          busy_q  <= 1'b0;
          state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign bus.mode         = mode_q;
  assign bus.dp_stop      = dp_stop_q;
  assign bus.dp_start     = dp_start_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.btn_level    = btn_level;

endmodule
